// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDUCtrl opcodes, latencies
// and sequencer states.
package mdu_pkg;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [2:0] OP_MFLO  = 3'b111;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;
    // CNT counts down to 0 inclusive, so it loads LAT-1
    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT_INIT = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } mdu_state_e;
endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath on the latched operands.
// Division works on magnitudes so INT_MIN / -1 wraps to 0x80000000 rem 0.
module mdu_arith (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] mul_hi,
    output logic [31:0] mul_lo,
    output logic [31:0] div_q,
    output logic [31:0] div_r,
    output logic        div_zero
);
    logic        a_neg, b_neg;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;

    always_comb begin
        a_neg    = is_signed & a[31];
        b_neg    = is_signed & b[31];
        a_ext    = {{32{a_neg}}, a};
        b_ext    = {{32{b_neg}}, b};
        prod     = a_ext * b_ext;
        mul_hi   = prod[63:32];
        mul_lo   = prod[31:0];

        a_mag    = a_neg ? (~a + 32'd1) : a;
        b_mag    = b_neg ? (~b + 32'd1) : b;
        div_zero = (b == 32'd0);
        q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
        r_mag    = div_zero ? 32'd0 : (a_mag % b_mag);
        // quotient truncates toward zero; remainder follows the dividend
        div_q    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        div_r    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end
endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MDU sequencer: accepts mult/div from E-stage, holds HI/LO,
// handles mthi/mtlo/mfhi/mflo, and reports Busy to the stall controller.
module mdu_sequencer
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUEN,
    input  logic [2:0]  MDUCtrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut
);
    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d, opb_q, opb_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] mul_hi, mul_lo, div_q, div_r;
    logic        div_zero;

    mdu_arith u_arith (
        .a        (opa_q),
        .b        (opb_q),
        .is_signed(sgn_q),
        .mul_hi   (mul_hi),
        .mul_lo   (mul_lo),
        .div_q    (div_q),
        .div_r    (div_r),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        Start   = MDUEN && !MDUCtrl[2] && (state_q == ST_IDLE);
        Busy    = (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    opa_d   = A;
                    opb_d   = B;
                    sgn_d   = ~MDUCtrl[0];
                    state_d = MDUCtrl[1] ? ST_DIV : ST_MUL;
                    cnt_d   = MDUCtrl[1] ? DIV_CNT_INIT : MUL_CNT_INIT;
                end else if (MDUEN && MDUCtrl == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUEN && MDUCtrl == OP_MTLO) begin
                    lo_d = A;
                end
            end
            ST_MUL, ST_DIV: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (state_q == ST_MUL) begin
                        hi_d = mul_hi;
                        lo_d = mul_lo;
                    end else if (!div_zero) begin
                        hi_d = div_r;
                        lo_d = div_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

    always_comb begin
        MDUOut = 32'd0;
        if (MDUEN && MDUCtrl == OP_MFHI) MDUOut = hi_q;
        else if (MDUEN && MDUCtrl == OP_MFLO) MDUOut = lo_q;
    end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: scoreboard of expected {HI,LO}
// filled at issue, drained when the operation completes.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MDUEN;
    logic [2:0]  MDUCtrl;
    logic [31:0] A, B;
    logic        Start, Busy;
    logic [31:0] HI, LO, MDUOut;

    always #5 clk = ~clk;

    mdu_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .MDUEN  (MDUEN),
        .MDUCtrl(MDUCtrl),
        .A      (A),
        .B      (B),
        .Start  (Start),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    int          checks = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // reference model built from SV native signed/unsigned arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]     r;
        longint          sa, sb;
        longint unsigned ua, ub;
        int              sq, sr;
        r = {m_hi, m_lo};
        case (op)
            OP_MULT: begin
                sa = $signed(a);
                sb = $signed(b);
                r  = sa * sb;
            end
            OP_MULTU: begin
                ua = a;
                ub = b;
                r  = ua * ub;
            end
            OP_DIV: begin
                if (b == 32'd0) r = {m_hi, m_lo};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    r  = {sr, sq};
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) r = {a % b, a / b};
            end
            default: r = {m_hi, m_lo};
        endcase
        return r;
    endfunction

    task automatic run_long(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        sb_q.push_back(model(op, a, b));
        lat     = op[1] ? DIV_LAT : MUL_LAT;
        MDUEN   = 1'b1;
        MDUCtrl = op;
        A       = a;
        B       = b;
        #1 chk("start", {63'd0, Start}, 64'd1);
        step();
        MDUEN = 1'b0;
        A     = ~a;
        B     = ~b;
        for (int i = 1; i <= lat; i++) begin
            chk($sformatf("busy_c%0d", i), {63'd0, Busy}, 64'd1);
            step();
        end
        chk("busy_done", {63'd0, Busy}, 64'd0);
        exp = sb_q.pop_front();
        chk($sformatf("hilo_op%0d", op), {HI, LO}, exp);
        {m_hi, m_lo} = exp;
    endtask

    task automatic mov(input logic [2:0] op, input logic [31:0] a);
        MDUEN   = 1'b1;
        MDUCtrl = op;
        A       = a;
        #1 chk("mov_nostart", {63'd0, Start}, 64'd0);
        step();
        chk("mov_nobusy", {63'd0, Busy}, 64'd0);
        if (op == OP_MTHI) m_hi = a;
        else m_lo = a;
        MDUEN = 1'b0;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        reset   = 1'b0;
        MDUEN   = 1'b0;
        MDUCtrl = 3'd0;
        A       = 32'd0;
        B       = 32'd0;
        #12;
        chk("rst_busy", {63'd0, Busy}, 64'd0);
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_out", {32'd0, MDUOut}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // first edge after reset release accepts the mult
        run_long(OP_MULT, 32'd3, 32'hFFFF_FFFE);
        chk("mult_const", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        run_long(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        chk("multu_const", {HI, LO}, {32'h0000_0001, 32'hFFFF_FFFE});
        run_long(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        chk("div_const", {HI, LO}, {32'h0000_0001, 32'hFFFF_FFFD});
        run_long(OP_DIVU, 32'd5, 32'd0);
        chk("divu0_const", {HI, LO}, {32'h0000_0001, 32'hFFFF_FFFD});
        run_long(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_long(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {HI, LO}, {32'h0, 32'h8000_0000});
        run_long(OP_DIV, 32'hFFFF_FFF9, 32'd2);

        for (int k = 0; k < 8; k++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom >> $urandom_range(0, 31);
            run_long(rop, ra, rb);
        end

        // moves and reads
        mov(OP_MTHI, 32'h1234_5678);
        MDUEN = 1'b1; MDUCtrl = OP_MFHI;
        #1 chk("mfhi", {32'd0, MDUOut}, {32'd0, m_hi});
        chk("mfhi_nobusy", {63'd0, Busy}, 64'd0);
        mov(OP_MTLO, 32'hCAFE_F00D);
        MDUEN = 1'b1; MDUCtrl = OP_MFLO;
        #1 chk("mflo", {32'd0, MDUOut}, {32'd0, 32'hCAFE_F00D});
        MDUEN = 1'b0;
        #1 chk("mf_disabled", {32'd0, MDUOut}, 64'd0);
        step();

        // ops issued while busy are ignored
        sb_q.push_back(model(OP_MULT, 32'd6, 32'hFFFF_FFF9));
        MDUEN = 1'b1; MDUCtrl = OP_MULT; A = 32'd6; B = 32'hFFFF_FFF9;
        step();
        MDUEN = 1'b0;
        step();
        MDUEN = 1'b1; MDUCtrl = OP_DIV; A = 32'd100; B = 32'd3;
        #1 chk("busy_nostart", {63'd0, Start}, 64'd0);
        step();
        MDUCtrl = OP_MTLO; A = 32'hDEAD_BEEF;
        step();
        MDUEN = 1'b0;
        chk("ign_busy_c4", {63'd0, Busy}, 64'd1);
        step();
        chk("ign_busy_c5", {63'd0, Busy}, 64'd1);
        step();
        chk("ign_busy_done", {63'd0, Busy}, 64'd0);
        chk("ign_hilo", {HI, LO}, sb_q.pop_front());
        {m_hi, m_lo} = {HI, LO};
        step();
        chk("ign_still_idle", {63'd0, Busy}, 64'd0);

        // reset asserted in the middle of a divide
        MDUEN = 1'b1; MDUCtrl = OP_DIV; A = 32'd1000; B = 32'd7;
        step();
        MDUEN = 1'b0;
        step();
        step();
        chk("mid_div_busy", {63'd0, Busy}, 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", {63'd0, Busy}, 64'd0);
        chk("abort_hilo", {HI, LO}, 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1 reset = 1'b1;
        run_long(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        chk("post_rst_mult", {HI, LO}, {32'd1, 32'd0});

        if (sb_q.size() != 0) chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
